// File: rtl/sigma_point_stream_tx.sv
// UKF sigma-point transmitter: latches mean and scaled sqrt covariance, streams 2N+1 (weight, point) pairs.
// Optional build macro SIGMA_POINT_SAT_EN: saturating element add/sub instead of wrap-around.
module sigma_point_stream_tx #(
  parameter int          DIM_SIGMA = 5,
  parameter logic [31:0] W0        = 32'h0000_92FA,
  parameter logic [31:0] WI        = 32'h0000_0AE7,
  parameter int          IDX_W     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [32*DIM_SIGMA-1:0]              x_mean,
  input  logic [32*DIM_SIGMA*DIM_SIGMA-1:0]    sqrt_p,
  output logic                                 sp_valid,
  input  logic                                 sp_ready,
  output logic [32*DIM_SIGMA-1:0]              sp_data,
  output logic [31:0]                          sp_weight,
  output logic [IDX_W-1:0]                     sp_index,
  output logic                                 sp_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int DATA_W = 32;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(2 * DIM_SIGMA);
  localparam logic [IDX_W-1:0] FIRST_SUB = IDX_W'(DIM_SIGMA + 1);

  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;

  logic signed [DATA_W-1:0] mean_p0 [DIM_SIGMA];
  logic signed [DATA_W-1:0] col_p0  [DIM_SIGMA][DIM_SIGMA];

  logic [IDX_W-1:0]           nxt_idx;
  logic                       nxt_sub;
  logic signed [DATA_W-1:0]   col_sel [DIM_SIGMA];
  logic [DATA_W*DIM_SIGMA-1:0] nxt_data;

`ifdef SIGMA_POINT_SAT_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 32'sh8000_0000;
`endif

  function automatic logic signed [DATA_W-1:0] add_sat(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] s;
    s = a + b;
`ifdef SIGMA_POINT_SAT_EN
    if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
      s = a[DATA_W-1] ? SAT_MIN : SAT_MAX;
`endif
    return s;
  endfunction

  function automatic logic signed [DATA_W-1:0] sub_sat(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] d;
    d = a - b;
`ifdef SIGMA_POINT_SAT_EN
    if ((a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]))
      d = a[DATA_W-1] ? SAT_MIN : SAT_MAX;
`endif
    return d;
  endfunction

  // Stage p0: operand latch, data only
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < DIM_SIGMA; i++) begin
        mean_p0[i] <= x_mean[DATA_W*i +: DATA_W];
        for (int j = 0; j < DIM_SIGMA; j++)
          col_p0[j][i] <= sqrt_p[DATA_W*(j*DIM_SIGMA+i) +: DATA_W];
      end
    end
  end

  // Points 1..N add column k-1, points N+1..2N subtract column k-N-1
  always_comb begin
    nxt_idx = sp_index + IDX_W'(1);
    nxt_sub = (nxt_idx >= FIRST_SUB);
    nxt_data = '0;
    for (int i = 0; i < DIM_SIGMA; i++)
      col_sel[i] = '0;
    for (int j = 0; j < DIM_SIGMA; j++) begin
      if ((!nxt_sub && nxt_idx == IDX_W'(j + 1)) ||
          ( nxt_sub && nxt_idx == IDX_W'(j + DIM_SIGMA + 1))) begin
        for (int i = 0; i < DIM_SIGMA; i++)
          col_sel[i] = col_p0[j][i];
      end
    end
    for (int i = 0; i < DIM_SIGMA; i++)
      nxt_data[DATA_W*i +: DATA_W] = nxt_sub ? sub_sat(mean_p0[i], col_sel[i])
                                             : add_sat(mean_p0[i], col_sel[i]);
  end

  // Stage p1: registered stream outputs and control FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sp_valid  <= 1'b0;
      sp_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sp_data   <= '0;
      sp_weight <= '0;
      sp_index  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sp_valid  <= 1'b1;
            sp_index  <= '0;
            sp_data   <= x_mean;
            sp_weight <= W0;
            sp_last   <= 1'b0;
            busy      <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          done <= 1'b0;
          if (sp_valid && sp_ready) begin
            if (sp_last) begin
              sp_valid <= 1'b0;
              sp_last  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              sp_index  <= nxt_idx;
              sp_data   <= nxt_data;
              sp_weight <= WI;
              sp_last   <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_point_stream_tx.sv
// Randomized bench for sigma_point_stream_tx against a plain-arithmetic reference model.
module tb_sigma_point_stream_tx;

  localparam int N    = 5;
  localparam int NPTS = 2 * N + 1;
  localparam int DW   = 32 * N;
  localparam logic [31:0] W0 = 32'h0000_92FA;
  localparam logic [31:0] WI = 32'h0000_0AE7;

  logic            clk = 1'b0;
  logic            rst_n, start, sp_ready;
  logic [DW-1:0]   x_mean;
  logic [DW*N-1:0] sqrt_p;
  logic            sp_valid, sp_last, busy, done;
  logic [DW-1:0]   sp_data;
  logic [31:0]     sp_weight;
  logic [3:0]      sp_index;

  sigma_point_stream_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_mean(x_mean), .sqrt_p(sqrt_p),
    .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_data(sp_data), .sp_weight(sp_weight),
    .sp_index(sp_index), .sp_last(sp_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0]   m_mean [N];
  logic [31:0]   m_col  [N][N];
  logic [DW-1:0] cap    [NPTS];
  logic [31:0]   wsum;
  int            cyc_used;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_point(input int k);
    logic [DW-1:0] v;
    longint e;
    v = '0;
    for (int i = 0; i < N; i++) begin
      e = longint'($signed(m_mean[i]));
      if (k >= 1 && k <= N)
        e = e + longint'($signed(m_col[k-1][i]));
      else if (k > N)
        e = e - longint'($signed(m_col[k-N-1][i]));
`ifdef SIGMA_POINT_SAT_EN
      if (e > 64'sd2147483647)  e = 64'sd2147483647;
      if (e < -64'sd2147483648) e = -64'sd2147483648;
`endif
      v[32*i +: 32] = e[31:0];
    end
    return v;
  endfunction

  task automatic clear_operands();
    for (int i = 0; i < N; i++) begin
      m_mean[i] = '0;
      for (int j = 0; j < N; j++) m_col[j][i] = '0;
    end
  endtask

  task automatic random_operands();
    for (int i = 0; i < N; i++) begin
      m_mean[i] = $urandom;
      for (int j = 0; j < N; j++) m_col[j][i] = $urandom;
    end
  endtask

  task automatic pulse_start();
    for (int i = 0; i < N; i++) begin
      x_mean[32*i +: 32] = m_mean[i];
      for (int j = 0; j < N; j++) sqrt_p[32*(j*N+i) +: 32] = m_col[j][i];
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Entered one cycle after start was sampled; leaves in the done cycle.
  task automatic run_stream(input int stall_at, input int stall_len, input bit rand_ready,
                            input bit poke_start);
    int k, stalls, budget;
    bit poked;
    k = 0; stalls = 0; budget = 0; poked = 1'b0;
    wsum = '0; cyc_used = 0;
    while (k < NPTS && budget < 2000) begin
      check("valid", {159'b0, sp_valid}, 1);
      check("index", {156'b0, sp_index}, k);
      check("data", sp_data, model_point(k));
      check("weight", {128'b0, sp_weight}, (k == 0) ? W0 : WI);
      check("last", {159'b0, sp_last}, (k == NPTS-1) ? 1 : 0);
      check("busy", {159'b0, busy}, 1);
      check("done_mid", {159'b0, done}, 0);
      cap[k] = sp_data;
      start = 1'b0;
      if (poke_start && k == 2 && !poked) begin
        poked = 1'b1;
        start = 1'b1;
        for (int i = 0; i < N; i++) x_mean[32*i +: 32] = $urandom;
        for (int i = 0; i < N*N; i++) sqrt_p[32*i +: 32] = $urandom;
      end
      if (k == stall_at && stalls < stall_len) begin
        sp_ready = 1'b0;
        stalls++;
      end else begin
        sp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (sp_ready) wsum = wsum + sp_weight;
      @(posedge clk); #1;
      budget++; cyc_used++;
      if (sp_ready) k++;
    end
    start = 1'b0;
    if (k < NPTS) check("timeout", 0, 1);
    check("done_pulse", {159'b0, done}, 1);
    check("valid_end", {159'b0, sp_valid}, 0);
    check("busy_end", {159'b0, busy}, 0);
    check("last_end", {159'b0, sp_last}, 0);
  endtask

  task automatic idle_cycle();
    sp_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check("idle_done", {159'b0, done}, 0);
    check("idle_valid", {159'b0, sp_valid}, 0);
    check("idle_busy", {159'b0, busy}, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; sp_ready = 1'b1;
    x_mean = '1; sqrt_p = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {159'b0, sp_valid}, 0);
    check("rst_busy", {159'b0, busy}, 0);
    check("rst_done", {159'b0, done}, 0);
    check("rst_last", {159'b0, sp_last}, 0);
    check("rst_data", sp_data, 0);
    check("rst_weight", {128'b0, sp_weight}, 0);
    check("rst_index", {156'b0, sp_index}, 0);
    rst_n = 1'b1; start = 1'b0;
    idle_cycle();

    // Basic stream with a 3-cycle stall at point 2
    clear_operands();
    m_mean[0] = 32'h0001_0000; m_mean[1] = 32'h0002_0000;
    m_col[0][0] = 32'h0000_8000; m_col[1][1] = 32'h0000_4000;
    pulse_start();
    run_stream(2, 3, 1'b0, 1'b0);
    check("stall_cycles", cyc_used, NPTS + 3);
    check("pt1", {96'b0, cap[1][63:0]}, {96'b0, 32'h0002_0000, 32'h0001_8000});
    check("pt2", {96'b0, cap[2][63:0]}, {96'b0, 32'h0002_4000, 32'h0001_0000});
    check("ptN1", {96'b0, cap[N+1][63:0]}, {96'b0, 32'h0002_0000, 32'h0000_8000});
    check("ptN2", {96'b0, cap[N+2][63:0]}, {96'b0, 32'h0001_C000, 32'h0001_0000});
    check("wsum", {128'b0, wsum}, 32'h0001_0000);

    // Back-to-back stream with start poked mid-stream and random backpressure
    random_operands();
    pulse_start();
    run_stream(-1, 0, 1'b1, 1'b1);
    check("wsum_rand", {128'b0, wsum}, 32'h0001_0000);
    idle_cycle();

    // Overflow boundaries
    clear_operands();
    m_mean[0] = 32'h7FFF_0000; m_col[0][0] = 32'h0002_0000;
    m_mean[1] = 32'h8001_0000; m_col[0][1] = 32'h0002_0000;
    pulse_start();
    run_stream(-1, 0, 1'b0, 1'b0);
`ifdef SIGMA_POINT_SAT_EN
    check("ovf_pos", {128'b0, cap[1][31:0]}, 32'h7FFF_FFFF);
    check("ovf_neg", {128'b0, cap[N+1][63:32]}, 32'h8000_0000);
`else
    check("ovf_pos", {128'b0, cap[1][31:0]}, 32'h8001_0000);
    check("ovf_neg", {128'b0, cap[N+1][63:32]}, 32'h7FFF_0000);
`endif
    check("ovf_sub", {128'b0, cap[N+1][31:0]}, 32'h7FFD_0000);
    idle_cycle();

    repeat (4) begin
      random_operands();
      pulse_start();
      run_stream(-1, 0, 1'b1, 1'b0);
      idle_cycle();
    end

    // Reset asserted mid-stream at point 3
    random_operands();
    pulse_start();
    sp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_index", {156'b0, sp_index}, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_valid", {159'b0, sp_valid}, 0);
    check("mrst_busy", {159'b0, busy}, 0);
    check("mrst_index", {156'b0, sp_index}, 0);
    check("mrst_done", {159'b0, done}, 0);
    repeat (3) idle_cycle();
    random_operands();
    pulse_start();
    run_stream(-1, 0, 1'b0, 1'b0);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sigma_point_stream_tx.md
Name: sigma_point_stream_tx

Overview:
- Sequential producer of UKF sigma points for the matrix-expectation datapath.
- Latches a mean vector and a scaled square-root covariance matrix on start.
- Streams 2*DIM+1 sigma points, each paired with its weight, over a valid/ready handshake.
- Is the transmitter end of the (weight, sigma) interface consumed by the pe_matrix_expectation accumulator chain. All values are Q16.16 two's complement.

Parameters:
- DIM_SIGMA, 5, state dimension N; number of points is 2N+1.
- W0, 32'h0000_92FA, Q16.16 weight of point 0 (mean).
- WI, 32'h0000_0AE7, Q16.16 weight of points 1..2N.
- IDX_W, 4, width of sp_index; must satisfy 2^IDX_W >= 2N+1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to latch inputs and begin a stream.
- x_mean  input  32*DIM_SIGMA  mean vector; element i at [32i+31:32i].
- sqrt_p  input  32*DIM_SIGMA*DIM_SIGMA  scaled sqrt covariance; column j, element i at [32(j*N+i)+31 : 32(j*N+i)].
- sp_valid  output  1  sigma point presented.
- sp_ready  input  1  consumer accepts point when sp_valid && sp_ready.
- sp_data  output  32*DIM_SIGMA  sigma point vector, same packing as x_mean.
- sp_weight  output  32  weight for the current point.
- sp_index  output  IDX_W  point number, 0..2N.
- sp_last  output  1  high with point 2N.
- busy  output  1  stream in progress.
- done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - State goes to IDLE.
  - sp_valid, sp_last, busy and done go to 0.
  - sp_data, sp_weight and sp_index go to 0.
  - Reset overrides all other inputs, including reset asserted mid-stream: the stream is abandoned and no done pulse is issued.
- FSM has two states, IDLE and EMIT.
- IDLE:
  - start=1 latches x_mean and sqrt_p into internal registers.
  - Next cycle: sp_valid=1, sp_index=0, sp_data=mean, sp_weight=W0, busy=1, state EMIT.
  - Latency from start to first valid is 1 cycle.
- EMIT:
  - On sp_valid && sp_ready, the index advances by 1 at that edge and the next point is registered with no bubble.
  - Point ordering:
    - k=1..N: mean + column(k-1).
    - k=N+1..2N: mean - column(k-N-1).
    - Weight is WI for all of these points.
  - sp_last=1 exactly when sp_index=2N.
  - Handshake on the last point: next cycle sp_valid=0, sp_last=0, busy=0, done=1 for one cycle, state IDLE.
  - A new start is accepted in the cycle done is high, giving back-to-back streams.
- Stall rule: while sp_valid && !sp_ready, sp_data, sp_weight, sp_index and sp_last hold stable.
- start is ignored while busy; latched operands are immune to input changes during EMIT.
- Arithmetic:
  - Per-element 32-bit add/sub of latched values.
  - Without the optional feature, results wrap modulo 2^32.
- sp_ready is don't-care while sp_valid=0.
- sp_data is registered (no combinational input-to-output path).

Optional Feature:
- Macro: SIGMA_POINT_SAT_EN.
- Defined: each element add/sub saturates to the Q16.16 limits:
  - positive overflow gives 32'h7FFF_FFFF;
  - negative overflow gives 32'h8000_0000.
  - Overflow is detected from the operand and result signs.
- Undefined: plain wrap-around; no saturation logic synthesised.

Test Plan:
- Basic stream (DIM_SIGMA=2, W0=32'h0000_8000, WI=32'h0000_2000, sp_ready=1):
  - Stimulus: mean=(0001_0000, 0002_0000), col0=(0000_8000, 0), col1=(0, 0000_4000), start pulse.
  - Points 0..4, one per cycle, weights W0 then WI:
    - 0: (00010000, 00020000)
    - 1: (00018000, 00020000)
    - 2: (00010000, 00024000)
    - 3: (00008000, 00020000)
    - 4: (00010000, 0001C000)
  - sp_last only on index 4; done one cycle after.
- Backpressure: same stimulus, sp_ready=0 for 3 cycles at index 2 -> sp_data stays 00010000/00024000 and index stays 2 for all stall cycles; total stream takes 8 cycles.
- Overflow:
  - Stimulus: mean0=7FFF_0000, col0 element0=0002_0000.
  - Point 1 element0 = 7FFF_FFFF with SIGMA_POINT_SAT_EN defined, 8001_0000 without.
  - Point N+1 element0 = 7FFD_0000 in both builds.
- start during EMIT, with x_mean changed after the first start: ignored; all points still derive from the first latched operands; single done.
- Reset mid-stream:
  - Stimulus: rst_n=0 for one cycle at index 3.
  - Next cycle sp_valid=0, busy=0, sp_index=0, done never pulses.
  - A following start produces index 0 again.
- Default DIM_SIGMA=5 weights: sum of streamed sp_weight over 11 points = 32'h0001_0000 exactly; sp_index runs 0..10; sp_last on 10.
